keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad on a Pmod header and turns keypresses into debounced 4-bit key events.
- It is the input-side counterpart of the board's multiplexed 7-segment display driver. It uses the same scheme: a free-running prescaler whose MSB rising edge gives a one-cycle scan tick, and a 3-state-free column walk.
- Events are latched into a pending flag that software or an interrupt source acknowledges.

---
 rtl/keypad_scanner_pkg.sv | 26 ++
 rtl/keypad_scanner_if.sv | 36 +++
 rtl/keypad_scanner_scan_tick_gen.sv | 31 +++
 rtl/keypad_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM states, the frame classification and the idle column pattern.
package keypad_scanner_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StPressed
   } state_e;

   typedef enum logic [1:0] {
      CandNone,
      CandKey,
      CandMulti
   } cand_e;

   // One scan frame reduced to what the debouncer cares about.
   typedef struct packed {
      cand_e      cls;
      logic [3:0] code;
   } cand_t;

   localparam logic [3:0] ColIdle = 4'b1111;

   localparam cand_t CandReset = '{cls: CandNone, code: 4'd0};

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key-event/acknowledge handshake of the scanner.
// master is the scanner side, slave is the consumer (keypad model, software, irq logic).
interface keypad_scanner_if;

   logic [3:0] ROW;
   logic [3:0] COL;
   logic [3:0] KEYCODE;
   logic       KEY_VALID;
   logic       KEY_HELD;
   logic       KEY_PENDING;
   logic       KEY_OVERRUN;
   logic       KEY_ACK;

   modport master (
      input  ROW,
      input  KEY_ACK,
      output COL,
      output KEYCODE,
      output KEY_VALID,
      output KEY_HELD,
      output KEY_PENDING,
      output KEY_OVERRUN
   );

   modport slave (
      output ROW,
      output KEY_ACK,
      input  COL,
      input  KEYCODE,
      input  KEY_VALID,
      input  KEY_HELD,
      input  KEY_PENDING,
      input  KEY_OVERRUN
   );

endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running prescaler whose MSB rising edge yields a registered one-cycle tick.
// Shared with the 7-segment display driver so both walk their columns the same way.
module keypad_scanner_scan_tick_gen #(
   parameter int unsigned DIV_BITS = 16
) (
   input  logic clk,
   input  logic resetn,
   output logic o_tick
);

   localparam logic [DIV_BITS-1:0] DivOne = {{(DIV_BITS-1){1'b0}}, 1'b1};

   logic [DIV_BITS-1:0] r_div;
   logic                r_msb;
   logic                r_tick;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_div  <= '0;
         r_msb  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_div  <= r_div + DivOne;
         r_msb  <= r_div[DIV_BITS-1];
         r_tick <= r_div[DIV_BITS-1] & ~r_msb;
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column walk, per-frame classification, debounce FSM
// and a sticky pending/overrun event latch acknowledged by KEY_ACK.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int unsigned DIV_BITS   = 16,
   parameter int unsigned DEB_FRAMES = 4
) (
   input  logic              clk,
   input  logic              resetn,
   keypad_scanner_if.master  bus
);

   localparam logic [3:0] DebThresh = 4'(DEB_FRAMES);

   logic [3:0]  r_row_s1;
   logic [3:0]  r_row_s2;
   logic [1:0]  r_col_sel;
   logic [3:0]  r_col;
   logic [15:0] r_map;
   cand_t       r_prev_cand;
   logic [3:0]  r_deb_cnt;
   state_e      r_state;
   logic [3:0]  r_keycode;
   logic        r_valid;
   logic        r_held;
   logic        r_pending;
   logic        r_overrun;

   logic        w_tick;
   logic        w_frame_end;
   logic [15:0] w_map_full;
   cand_t       w_cand;
   logic [3:0]  w_deb_next;
   logic [1:0]  w_col_sel_next;
   state_e      w_state_next;
   logic        w_accept;
   logic        w_release;

   function automatic cand_t classify(input logic [15:0] map);
      cand_t       c;
      int unsigned n;
      c = CandReset;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (map[i]) begin
            n++;
            c.code = 4'(i);
         end
      end
      if (n == 1) begin
         c.cls = CandKey;
      end else if (n > 1) begin
         c.cls  = CandMulti;
         c.code = 4'd0;
      end else begin
         c.code = 4'd0;
      end
      return c;
   endfunction

   keypad_scanner_scan_tick_gen #(
      .DIV_BITS (DIV_BITS)
   ) u_tick (
      .clk    (clk),
      .resetn (resetn),
      .o_tick (w_tick)
   );

   // The sample of the column being scanned this tick is merged in before classifying.
   always_comb begin
      w_map_full = r_map;
      w_map_full[{r_col_sel, 2'b00} +: 4] = ~r_row_s2;
   end

   assign w_frame_end    = w_tick & (r_col_sel == 2'd3);
   assign w_cand         = classify(w_map_full);
   assign w_col_sel_next = r_col_sel + 2'd1;

   always_comb begin
      if (w_cand == r_prev_cand) begin
         w_deb_next = (r_deb_cnt == 4'hF) ? 4'hF : r_deb_cnt + 4'd1;
      end else begin
         w_deb_next = 4'd1;
      end
   end

   // MULTI frames never accept and never count towards a release.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_release    = 1'b0;
      if (w_frame_end) begin
         unique case (r_state)
            StIdle: begin
               if (w_cand.cls == CandKey && w_deb_next >= DebThresh) begin
                  w_state_next = StPressed;
                  w_accept     = 1'b1;
               end
            end
            StPressed: begin
               if (w_cand.cls == CandNone && w_deb_next >= DebThresh) begin
                  w_state_next = StIdle;
                  w_release    = 1'b1;
               end
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_row_s1    <= 4'b1111;
         r_row_s2    <= 4'b1111;
         r_col_sel   <= 2'd0;
         r_col       <= ColIdle ^ 4'b0001;
         r_map       <= '0;
         r_prev_cand <= CandReset;
         r_deb_cnt   <= 4'd0;
      end else begin
         r_row_s1 <= bus.ROW;
         r_row_s2 <= r_row_s1;
         if (w_tick) begin
            r_col_sel <= w_col_sel_next;
            r_col     <= ColIdle ^ (4'b0001 << w_col_sel_next);
            r_map     <= w_frame_end ? 16'd0 : w_map_full;
         end
         if (w_frame_end) begin
            r_prev_cand <= w_cand;
            r_deb_cnt   <= w_deb_next;
         end
      end
   end

   // An accept coinciding with KEY_ACK wins and leaves OVERRUN untouched.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_keycode <= 4'd0;
         r_valid   <= 1'b0;
         r_held    <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) begin
            r_keycode <= w_cand.code;
            r_held    <= 1'b1;
         end else if (w_release) begin
            r_held <= 1'b0;
         end
         if (w_accept) begin
            r_pending <= 1'b1;
            if (r_pending && !bus.KEY_ACK) begin
               r_overrun <= 1'b1;
            end
         end else if (bus.KEY_ACK) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign bus.COL         = r_col;
   assign bus.KEYCODE     = r_keycode;
   assign bus.KEY_VALID   = r_valid;
   assign bus.KEY_HELD    = r_held;
   assign bus.KEY_PENDING = r_pending;
   assign bus.KEY_OVERRUN = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized key/ack traffic.
module tb_keypad_scanner;

   localparam int unsigned DivBits   = 4;
   localparam int unsigned DebFrames = 4;
   localparam int unsigned TickPer   = 1 << DivBits;
   localparam int unsigned FirstSmp  = (1 << (DivBits - 1)) + 2;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic        ack    = 1'b0;
   logic [15:0] keys   = 16'd0;
   logic [3:0]  row_drive;
   bit          chk_en = 1'b0;

   int total = 0;
   int bad   = 0;
   int vcnt  = 0;

   // Model state: cycles since reset release and the user-visible key behaviour.
   int unsigned cyc;
   int          frame_cnt = 0;
   int          run_len;
   int          last_cls;
   int          last_code;
   bit          m_pressed;
   logic [3:0]  m_code;
   bit          m_valid;
   bit          m_pending;
   bit          m_overrun;
   logic [3:0]  m_col;

   keypad_scanner_if kif ();

   keypad_scanner #(
      .DIV_BITS   (DivBits),
      .DEB_FRAMES (DebFrames)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (kif)
   );

   always #5 clk = ~clk;

   // Ideal keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_drive = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (keys[4*c+r] && !kif.COL[c]) row_drive[r] = 1'b0;
         end
      end
   end

   assign kif.ROW     = row_drive;
   assign kif.KEY_ACK = ack;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 30) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
         end
      end
   endtask

   task automatic model_reset();
      cyc       = 0;
      run_len   = 0;
      last_cls  = 0;
      last_code = 0;
      m_pressed = 0;
      m_code    = 4'd0;
      m_valid   = 0;
      m_pending = 0;
      m_overrun = 0;
      m_col     = 4'b1110;
   endtask

   task automatic model_step();
      int cls;
      int code;
      int nk;
      int sel;
      bit accept;
      cyc++;
      accept  = 0;
      m_valid = 0;
      // Column samples happen FirstSmp cycles after release, then every tick period.
      if (cyc >= FirstSmp && (cyc - FirstSmp) % TickPer == 0 &&
          ((cyc - FirstSmp) / TickPer) % 4 == 3) begin
         nk   = $countones(keys);
         code = 0;
         for (int i = 0; i < 16; i++) if (keys[i]) code = i;
         cls  = (nk == 0) ? 0 : (nk == 1) ? 1 : 2;
         if (cls != 1) code = 0;
         if (cls == last_cls && code == last_code) run_len = (run_len < 15) ? run_len + 1 : 15;
         else run_len = 1;
         last_cls  = cls;
         last_code = code;
         if (!m_pressed && cls == 1 && run_len >= DebFrames) begin
            accept    = 1;
            m_pressed = 1;
            m_code    = 4'(code);
         end else if (m_pressed && cls == 0 && run_len >= DebFrames) begin
            m_pressed = 0;
         end
         frame_cnt++;
      end
      sel     = (cyc >= FirstSmp) ? (((cyc - FirstSmp) / TickPer) + 1) % 4 : 0;
      m_col   = ~(4'b0001 << sel);
      m_valid = accept;
      if (accept) begin
         if (m_pending && !ack) m_overrun = 1;
         m_pending = 1;
      end else if (ack) begin
         m_pending = 0;
         m_overrun = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) model_reset();
         else model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            if (kif.KEY_VALID) vcnt++;
            check("col",     32'(kif.COL),         32'(m_col));
            check("keycode", 32'(kif.KEYCODE),     32'(m_code));
            check("valid",   32'(kif.KEY_VALID),   32'(m_valid));
            check("held",    32'(kif.KEY_HELD),    32'(m_pressed));
            check("pending", 32'(kif.KEY_PENDING), 32'(m_pending));
            check("overrun", 32'(kif.KEY_OVERRUN), 32'(m_overrun));
         end
      end
   end

   // Apply k for n whole frames; called just after a frame end so frames stay clean.
   task automatic run_frames(input logic [15:0] k, input int n, input int ack_pct);
      int target;
      int budget;
      keys   = k;
      target = frame_cnt + n;
      budget = 64 * n + 16;
      while (frame_cnt < target && budget > 0) begin
         @(negedge clk);
         ack = (ack_pct != 0 && $urandom_range(0, 99) < ack_pct);
         budget--;
      end
      if (frame_cnt < target) check("frame_timeout", 32'(frame_cnt), 32'(target));
      @(negedge clk);
      ack = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      int          v0;
      int          sel;
      int          len;
      logic [15:0] k;
      logic [3:0]  kc;
      logic [3:0]  kd;
      logic [3:0]  last_key;

      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_col", 32'(kif.COL), 32'h0000000e);
      check("rst_pending", 32'(kif.KEY_PENDING), 32'd0);
      resetn = 1'b1;
      repeat (FirstSmp - 1) @(posedge clk);
      #1 check("col_before_tick", 32'(kif.COL), 32'h0000000e);
      @(posedge clk);
      #1 check("col_after_tick", 32'(kif.COL), 32'h0000000d);

      // Idle with no keys for roughly 1000 cycles.
      run_frames(16'd0, 15, 0);
      check("idle_no_event", 32'(vcnt), 32'd0);

      // Key at col 1, row 2.
      v0 = vcnt;
      run_frames(16'h0040, 4, 0);
      check("press6_pulses", 32'(vcnt - v0), 32'd1);
      check("press6_code", 32'(kif.KEYCODE), 32'd6);
      check("press6_held", 32'(kif.KEY_HELD), 32'd1);
      check("press6_pending", 32'(kif.KEY_PENDING), 32'd1);
      run_frames(16'd0, 3, 0);
      check("release3_held", 32'(kif.KEY_HELD), 32'd1);
      run_frames(16'd0, 1, 0);
      check("release4_held", 32'(kif.KEY_HELD), 32'd0);
      pulse_ack();

      // Bounce: 2 frames on, 1 off, then 4 stable frames.
      v0 = vcnt;
      run_frames(16'h0200, 2, 0);
      run_frames(16'd0, 1, 0);
      run_frames(16'h0200, 3, 0);
      check("bounce_none_yet", 32'(vcnt - v0), 32'd0);
      run_frames(16'h0200, 1, 0);
      check("bounce_one", 32'(vcnt - v0), 32'd1);
      check("bounce_code", 32'(kif.KEYCODE), 32'd9);
      run_frames(16'd0, 4, 0);
      pulse_ack();

      // Two keys then one of them released.
      v0 = vcnt;
      run_frames(16'h0021, 8, 0);
      check("multi_no_event", 32'(vcnt - v0), 32'd0);
      run_frames(16'h0001, 4, 0);
      check("multi_then_0", 32'(vcnt - v0), 32'd1);
      check("multi_code0", 32'(kif.KEYCODE), 32'd0);
      run_frames(16'd0, 4, 0);
      pulse_ack();

      // Overrun and acknowledge.
      run_frames(16'h0008, 4, 0);
      run_frames(16'd0, 4, 0);
      run_frames(16'h1000, 4, 0);
      check("ovr_code", 32'(kif.KEYCODE), 32'd12);
      check("ovr_flag", 32'(kif.KEY_OVERRUN), 32'd1);
      pulse_ack();
      @(negedge clk);
      check("ack_pending", 32'(kif.KEY_PENDING), 32'd0);
      check("ack_overrun", 32'(kif.KEY_OVERRUN), 32'd0);
      run_frames(16'd0, 4, 0);

      // ACK landing exactly on the accepting frame end.
      v0 = vcnt;
      run_frames(16'h0200, 3, 0);
      repeat (62) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      check("coinc_pulse", 32'(vcnt - v0), 32'd1);
      check("coinc_pending", 32'(kif.KEY_PENDING), 32'd1);
      check("coinc_overrun", 32'(kif.KEY_OVERRUN), 32'd0);
      run_frames(16'd0, 4, 0);
      pulse_ack();

      // Reset in the middle of the third debounce frame.
      run_frames(16'h0400, 2, 0);
      repeat (20) @(negedge clk);
      #3 resetn = 1'b0;
      #1;
      check("mid_rst_col", 32'(kif.COL), 32'h0000000e);
      check("mid_rst_code", 32'(kif.KEYCODE), 32'd0);
      check("mid_rst_held", 32'(kif.KEY_HELD), 32'd0);
      check("mid_rst_pending", 32'(kif.KEY_PENDING), 32'd0);
      repeat (3) @(negedge clk);
      #3 resetn = 1'b1;
      v0 = vcnt;
      run_frames(16'h0400, 3, 0);
      check("post_rst_none", 32'(vcnt - v0), 32'd0);
      run_frames(16'h0400, 1, 0);
      check("post_rst_one", 32'(vcnt - v0), 32'd1);
      check("post_rst_code", 32'(kif.KEYCODE), 32'd10);

      // Random key patterns with random acknowledges.
      last_key = 4'd0;
      for (int seg = 0; seg < 60; seg++) begin
         sel = $urandom_range(0, 9);
         len = $urandom_range(1, 6);
         kc  = 4'($urandom_range(0, 15));
         kd  = kc + 4'($urandom_range(1, 15));
         if (sel < 4) begin
            k = 16'd0;
         end else if (sel < 8) begin
            if ($urandom_range(0, 1) == 1) kc = last_key;
            k        = 16'd1 << kc;
            last_key = kc;
         end else begin
            k = (16'd1 << kc) | (16'd1 << kd);
         end
         run_frames(k, len, 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
